// File: rtl/tty_pkg.sv
// tty_pkg: FSM state type and UART frame constants shared by the TTY transmitter.
package tty_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tty_state_e;
   localparam int   TTY_DATA_BITS = 8;
   localparam logic TTY_START_BIT = 1'b0;
   localparam logic TTY_STOP_BIT  = 1'b1;
endpackage

// File: rtl/tty_fifo.sv
// tty_fifo: synchronous FIFO of 7-bit characters, depth 2**AW, wrapping AW+1-bit pointers.
module tty_fifo #(
   parameter int AW = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [6:0] din,
   output logic [6:0] dout,
   output logic       full,
   output logic       empty
);
   logic [6:0]  mem [2**AW];
   logic [AW:0] wp, rp;
   assign dout  = mem[rp[AW-1:0]];
   assign empty = wp == rp;
   assign full  = wp == {~rp[AW], rp[AW-1:0]};
   always_ff @(posedge clk)
      if (push) mem[wp[AW-1:0]] <= din;
   always_ff @(posedge clk)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end
endmodule

// File: rtl/tty_uart_tx.sv
// tty_uart_tx: buffered UART transmitter for MCU TTY character strobes (8N1).
// Define TTY_PARITY_EN to insert an even parity bit (8E1).
module tty_uart_tx
   import tty_pkg::*;
#(
   parameter int CLK_DIV = 104,
   parameter int FIFO_AW = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] tty_data_i,
   input  logic       tty_we_i,
   output logic       uart_tx_o,
   output logic       busy_o,
   output logic       full_o,
   output logic       overflow_o
);
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
   tty_state_e    state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [6:0]    head, data_q;
   logic          we_q, empty, full, pop, push, bit_end;
`ifdef TTY_PARITY_EN
   logic          par;
`endif
   // strobes are registered first so the FIFO and flags see no input-to-output paths
   assign pop     = state == IDLE && !empty;
   assign push    = we_q && (!full || pop);
   assign bit_end = baud == '0;
   assign busy_o  = state != IDLE || !empty;
   assign full_o  = full;
   tty_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk  (clk_i),
      .rst  (rst_i),
      .push (push),
      .pop  (pop),
      .din  (data_q),
      .dout (head),
      .full (full),
      .empty(empty)
   );
   always_ff @(posedge clk_i)
      if (rst_i) begin
         we_q   <= 1'b0;
         data_q <= '0;
      end else begin
         we_q   <= tty_we_i;
         data_q <= tty_data_i;
      end
   always_ff @(posedge clk_i)
      if (rst_i) begin
         state      <= IDLE;
         baud       <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         uart_tx_o  <= 1'b1;
         overflow_o <= 1'b0;
`ifdef TTY_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         if (we_q && full && !pop) overflow_o <= 1'b1;
         case (state)
            IDLE: if (!empty) begin
               state     <= START;
               baud      <= BAUD_MAX;
               shreg     <= {1'b0, head};
               uart_tx_o <= TTY_START_BIT;
`ifdef TTY_PARITY_EN
               par       <= ^head;
`endif
            end
            START: if (bit_end) begin
               state     <= DATA;
               baud      <= BAUD_MAX;
               bit_cnt   <= '0;
               uart_tx_o <= shreg[0];
            end else baud <= baud - 1'b1;
            DATA: if (bit_end) begin
               baud    <= BAUD_MAX;
               bit_cnt <= bit_cnt + 1'b1;
               shreg   <= shreg >> 1;
               if (bit_cnt == 3'(TTY_DATA_BITS - 1)) begin
`ifdef TTY_PARITY_EN
                  state     <= PARITY;
                  uart_tx_o <= par;
`else
                  state     <= STOP;
                  uart_tx_o <= TTY_STOP_BIT;
`endif
               end else uart_tx_o <= shreg[1];
            end else baud <= baud - 1'b1;
`ifdef TTY_PARITY_EN
            PARITY: if (bit_end) begin
               state     <= STOP;
               baud      <= BAUD_MAX;
               uart_tx_o <= TTY_STOP_BIT;
            end else baud <= baud - 1'b1;
`endif
            STOP: if (bit_end) begin
               state     <= IDLE;
               uart_tx_o <= TTY_STOP_BIT;
            end else baud <= baud - 1'b1;
            default: begin
               state     <= IDLE;
               uart_tx_o <= TTY_STOP_BIT;
            end
         endcase
      end
endmodule

// File: tb/tb_tty_uart_tx.sv
// tb_tty_uart_tx: frame-level model plus line receiver checking tty_uart_tx with CLK_DIV=4, FIFO_AW=2.
module tb_tty_uart_tx;
   localparam int D = 4;
   localparam int DEPTH = 4;
`ifdef TTY_PARITY_EN
   localparam int P = 1;
   localparam bit A_BITS [11] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1};
`else
   localparam int P = 0;
   localparam bit A_BITS [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
`endif
   localparam int FL = 10 + P;
   logic clk = 1'b0, rst_i = 1'b1, tty_we_i = 1'b0;
   logic [6:0] tty_data_i = '0;
   logic uart_tx_o, busy_o, full_o, overflow_o;
   int total = 0, bad = 0;
   tty_uart_tx #(.CLK_DIV(D), .FIFO_AW(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .tty_data_i(tty_data_i), .tty_we_i(tty_we_i),
      .uart_tx_o(uart_tx_o), .busy_o(busy_o), .full_o(full_o), .overflow_o(overflow_o)
   );
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at cycle", name, act, exp);
      end
   endtask

   // Model: a queue of accepted characters and, for the frame on the wire, its start cycle.
   logic [6:0] mq [$];
   logic [6:0] m_char, w_data;
   bit m_act, m_ovf, m_valid, w_pend, m_pop, m_acc;
   int m_start, cyc = 0;
   function automatic logic frame_bit(input logic [6:0] c, input int k);
      logic [7:0] d;
      d = {1'b0, c};
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (k < FL - 1) return ^d;
      return 1'b1;
   endfunction
   always @(posedge clk) begin
      cyc++;
      if (rst_i) begin
         mq.delete();
         m_act = 0; m_ovf = 0; w_pend = 0; m_valid = 1;
      end else begin
         m_pop = !m_act && mq.size() > 0;
         m_acc = w_pend && (mq.size() < DEPTH || m_pop);
         if (w_pend && !m_acc) m_ovf = 1;
         if (m_act && cyc == m_start + FL * D) m_act = 0;
         if (m_pop) begin
            m_char = mq.pop_front();
            m_act = 1;
            m_start = cyc;
         end
         if (m_acc) mq.push_back(w_data);
         w_pend = tty_we_i;
         w_data = tty_data_i;
      end
   end
   always @(negedge clk)
      if (m_valid) begin
         chk("tx", uart_tx_o, m_act ? frame_bit(m_char, (cyc - m_start) / D) : 1'b1);
         chk("busy", busy_o, m_act || mq.size() > 0);
         chk("full", full_o, mq.size() == DEPTH);
         chk("overflow", overflow_o, m_ovf);
      end

   // Receiver: decodes the DUT line mid-bit into characters and start cycles.
   logic [7:0] rxq [$];
   int rx_t [$];
   int rx_cnt = -1;
   logic [7:0] rx_sh;
   always @(negedge clk) begin
      if (rst_i || !m_valid) rx_cnt = -1;
      else if (rx_cnt < 0) begin
         if (uart_tx_o === 1'b0) begin
            rx_cnt = 0;
            rx_t.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % D == 1) begin
            if (rx_cnt / D >= 1 && rx_cnt / D <= 8) rx_sh[rx_cnt/D-1] = uart_tx_o;
`ifdef TTY_PARITY_EN
            if (rx_cnt / D == 9) chk("rx_parity", uart_tx_o, ^rx_sh);
`endif
            if (rx_cnt / D == FL - 1) begin
               chk("rx_stop", uart_tx_o, 1'b1);
               rxq.push_back(rx_sh);
               rx_cnt = -1;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [6:0] c);
      tty_we_i = 1'b1;
      tty_data_i = c;
      tick();
      tty_we_i = 1'b0;
   endtask
   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy_o !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      chk("wait_idle", busy_o, 1'b0);
   endtask
   task automatic clr_rx();
      rxq.delete();
      rx_t.delete();
   endtask

   initial begin
      logic [7:0] hi [3];
      hi = '{8'h48, 8'h69, 8'h21};
      tick(2);
      rst_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("rst_tx", uart_tx_o, 1'b1);
         chk("rst_busy", busy_o, 1'b0);
         tick();
      end
      // single 'A': entry visible one cycle after the strobe edge, line falls the cycle after
      clr_rx();
      wr(7'h41);
      chk("a_pre_busy", busy_o, 1'b0);
      tick();
      chk("a_vis_busy", busy_o, 1'b1);
      chk("a_vis_tx", uart_tx_o, 1'b1);
      tick();
      for (int i = 0; i < FL * D; i++) begin
         chk("a_bit", uart_tx_o, A_BITS[i/D]);
         tick();
      end
      chk("a_end_busy", busy_o, 1'b0);
      chk("a_end_tx", uart_tx_o, 1'b1);
      chk("a_rx", rxq.size() > 0 ? rxq[0] : 8'hff, 8'h41);
      // burst of three back-to-back strobes
      clr_rx();
      wr(7'h48); wr(7'h69); wr(7'h21);
      wait_idle(200);
      chk("hi_cnt", rxq.size(), 3);
      for (int i = 0; i < 3; i++) chk("hi_char", i < rxq.size() ? rxq[i] : 8'hff, hi[i]);
      chk("hi_gap0", rx_t.size() >= 3 ? rx_t[1] - rx_t[0] : 0, FL * D + 1);
      chk("hi_gap1", rx_t.size() >= 3 ? rx_t[2] - rx_t[1] : 0, FL * D + 1);
      // six strobes into a depth-4 FIFO: one popped, four stored, the sixth dropped
      clr_rx();
      for (int i = 0; i < 6; i++) wr(7'h61 + 7'(i));
      chk("ovf_full", full_o, 1'b1);
      chk("ovf_pre", overflow_o, 1'b0);
      tick();
      chk("ovf_set", overflow_o, 1'b1);
      wait_idle(400);
      chk("ovf_cnt", rxq.size(), 5);
      for (int i = 0; i < 5; i++) chk("ovf_char", i < rxq.size() ? rxq[i] : 8'hff, 8'h61 + 8'(i));
      chk("ovf_sticky", overflow_o, 1'b1);
      // strobe during STOP of the previous frame
      clr_rx();
      wr(7'h58);
      tick((FL - 1) * D + 1);
      wr(7'h55);
      wait_idle(200);
      chk("stop_cnt", rxq.size(), 2);
      chk("stop_gap", rx_t.size() >= 2 ? rx_t[1] - rx_t[0] : 0, FL * D + 1);
`ifdef TTY_PARITY_EN
      clr_rx();
      wr(7'h07);
      tick(2 + 9 * D);
      chk("par_bit", uart_tx_o, 1'b1);
      tick(2 * D - 1);
      chk("par_len_busy", busy_o, 1'b1);
      tick();
      chk("par_len_idle", busy_o, 1'b0);
`endif
      // reset mid-frame with a second character still queued
      clr_rx();
      wr(7'h5a); wr(7'h59);
      tick(10);
      chk("mid_tx_low_or_data", busy_o, 1'b1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("mrst_tx", uart_tx_o, 1'b1);
      chk("mrst_busy", busy_o, 1'b0);
      chk("mrst_full", full_o, 1'b0);
      chk("mrst_ovf", overflow_o, 1'b0);
      tick(30);
      chk("mrst_rx", rxq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tty_uart_tx.md
# tty_uart_tx

Serial console back-end for the MCU's TTY port. It consumes the 7-bit character strobes the bus decoder emits on `tty_o`/`tty_we_o`, buffers them in a small FIFO and serialises each one as an asynchronous UART frame on a single output pin. It sits directly downstream of the MCU top and absorbs single-cycle store bursts from the core without back-pressure.

## Interface
- `CLK_DIV`, default 104: clock cycles per UART bit. Legal range is 2..65535.
- `FIFO_AW`, default 4: FIFO address width. Depth is 2^FIFO_AW entries.
- `clk_i` in 1: system clock (same clock as the core).
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `tty_data_i` in 7: ASCII character, driven from MCU `tty_o`.
- `tty_we_i` in 1: write strobe, driven from MCU `tty_we_o`. Each high cycle writes one character.
- `uart_tx_o` out 1: serial line. Idle level is high. Registered.
- `busy_o` out 1: high while a frame is in flight or the FIFO is non-empty.
- `full_o` out 1: FIFO holds 2^FIFO_AW entries.
- `overflow_o` out 1: sticky. Set when a write is dropped; cleared only by reset.

## Operation
- Frame format: 1 start bit (0), then 8 data bits sent LSB first as `{1'b0, char[6:0]}`, then the optional parity bit, then 1 stop bit (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty. The head entry is popped into the shift register in the same cycle.
  - START -> DATA after CLK_DIV cycles.
  - DATA stays for 8 bits of CLK_DIV cycles each, tracked by a 3-bit bit counter. It then goes to PARITY (macro defined) or STOP (macro undefined).
  - PARITY -> STOP after CLK_DIV cycles.
  - STOP -> IDLE after CLK_DIV cycles.
- Baud counter:
  - Width is `$clog2(CLK_DIV)`.
  - Loads CLK_DIV-1 on every state or bit entry and counts down.
  - A bit ends at the cycle where the count is 0.
- FIFO write rules:
  - A write is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped and `overflow_o` is set on the next edge.
- FIFO pointers are FIFO_AW+1 bits wide. Full/empty are derived from the MSB compare, and the pointers wrap naturally.
- The core is never stalled; there is no ready signal back to the bus.

## Timing
- Reset values:
  - `uart_tx_o` = 1.
  - `busy_o` = 0, `full_o` = 0, `overflow_o` = 0.
  - FSM in IDLE, FIFO empty, both pointers 0, baud and bit counters 0.
- Reset takes effect at the next edge from any state. A frame in progress is abandoned, and the line returns high at that edge. This may truncate a frame on the wire; that is accepted behaviour.
- Latency, for a write at edge n into an empty FIFO with the FSM in IDLE:
  - The entry is visible at n+1.
  - The pop and START entry occur at edge n+2.
  - `uart_tx_o` falls at n+2 (driven from the registered next state).
- Back-to-back frames: STOP -> IDLE -> START adds exactly 1 idle cycle between frames.
- Each frame lasts (10 + P) × CLK_DIV + 1 cycles start-to-start, where P = 1 if parity is compiled in, else 0.
- `busy_o`, `full_o` and `overflow_o` are registered or derived from registers only; there are no combinational paths from the inputs.

## Configuration
- `TTY_PARITY_EN`:
  - Defined: the PARITY state is inserted, sending even parity, i.e. XOR of the 8 data bits. The frame is 8E1, 11 bits.
  - Undefined: the PARITY state and its logic are absent. The frame is 8N1, 10 bits.

## Structure
- Package `tty_pkg` holds:
  - the FSM state enum `tty_state_e`;
  - the frame constants `TTY_DATA_BITS` (8), `TTY_START_BIT` (0) and `TTY_STOP_BIT` (1).
- Sub-module `tty_fifo` is the synchronous FIFO:
  - storage of 7-bit entries;
  - ports `push`, `pop`, `full`, `empty`;
  - parameter `AW`.
- The top holds the FSM, the baud counter, the shift register and the overflow flag.

## Test plan
- Reset with `CLK_DIV`=4, no macro:
  - `uart_tx_o`=1 and `busy_o`=0 for 20 cycles.
  - Assert `rst_i` mid-frame -> line high at the next edge, FIFO empty.
- Single write 0x41 ('A'), 8N1 with `CLK_DIV`=4:
  - Line low 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high for 4 cycles.
  - `busy_o` drops after stop.
- Burst of 3 consecutive writes 'H','i','!' -> three frames in order, each separated by exactly 1 idle cycle.
- With `FIFO_AW`=2, 6 consecutive writes while IDLE:
  - 1 entry is popped.
  - `full_o` rises, the 6th write is dropped and `overflow_o`=1.
  - Exactly 5 characters are transmitted.
- `TTY_PARITY_EN` defined, write 0x07 -> parity bit 1, and the frame is 11 bits × `CLK_DIV`.
- Write during STOP of the previous frame with the FIFO otherwise empty -> the next frame starts at STOP-end + 1 cycle.
